// File: rtl/layer_pkg.sv
// Shared widths and the per-channel requantisation helper for the
// post-layer_1 ReLU + max-pool stage.
package layer_pkg;

  localparam int NUM_CH = 32;
  localparam int ACC_W  = 32;
  localparam int ACT_W  = 8;
  localparam logic [ACT_W-1:0] ACT_MAX = 8'd255;

  // ReLU, arithmetic right shift, then clamp to the unsigned activation range.
  function automatic logic [ACT_W-1:0] relu_sat(input logic signed [ACC_W-1:0] x,
                                                input int unsigned             sh);
    logic signed [ACC_W-1:0] y;
    y = x >>> sh;
    if (x[ACC_W-1])          return '0;
    if (|y[ACC_W-1:ACT_W])   return ACT_MAX;
    return y[ACT_W-1:0];
  endfunction

endpackage

// File: rtl/relu_maxpool_1_pool_ch.sv
// One channel of the pooling stage: requantise the incoming beat, hold the
// left pixel of the current horizontal pair, keep one pooled-row line buffer,
// and present the 2x2 window maximum combinationally.
module pool_ch
  import layer_pkg::*;
#(
  parameter int PW    = 13,
  parameter int LB_AW = 4,
  parameter int SHIFT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ACC_W-1:0] x,
  input  logic                    cap_pair,
  input  logic                    wr_line,
  input  logic [LB_AW-1:0]        lb_idx,
  output logic [ACT_W-1:0]        pooled
);

  logic [ACT_W-1:0] q;
  logic [ACT_W-1:0] m;
  logic [ACT_W-1:0] lb_rd;
  logic [ACT_W-1:0] pair_q, pair_d;
  logic [ACT_W-1:0] line_q [PW];
  logic [ACT_W-1:0] line_d [PW];

  // Requantise, fold in the held left pixel, then the stored upper-row max.
  always_comb begin
    q     = relu_sat(x, SHIFT);
    m     = (pair_q > q) ? pair_q : q;
    lb_rd = '0;
    for (int i = 0; i < PW; i++)
      if (lb_idx == LB_AW'(i)) lb_rd = line_q[i];
    pooled = (lb_rd > m) ? lb_rd : m;
  end

  // Next state: pair register on even columns, line buffer on even-row odd columns.
  always_comb begin
    pair_d = pair_q;
    line_d = line_q;
    if (cap_pair) pair_d = q;
    for (int i = 0; i < PW; i++)
      if (wr_line && lb_idx == LB_AW'(i)) line_d[i] = m;
  end

  // Pair and line-buffer storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q <= '0;
      for (int i = 0; i < PW; i++) line_q[i] <= '0;
    end else begin
      pair_q <= pair_d;
      for (int i = 0; i < PW; i++) line_q[i] <= line_d[i];
    end
  end

endmodule

// File: rtl/relu_maxpool_1.sv
// ReLU + requantise + 2x2/stride-2 max-pool on all layer_1 channels in
// parallel. Shared raster counters decode the window phase; each channel's
// datapath lives in pool_ch. Output is registered (latency 1).
module relu_maxpool_1
  import layer_pkg::*;
#(
  parameter int NUM_CH = layer_pkg::NUM_CH,
  parameter int IN_W   = 26,
  parameter int IN_H   = 26,
  parameter int SHIFT  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [NUM_CH*ACC_W-1:0]   data_in,
  output logic                      valid_out,
  output logic [NUM_CH*ACT_W-1:0]   data_out,
  output logic                      frame_done
);

  localparam int PW    = IN_W / 2;
  localparam int PH    = IN_H / 2;
  localparam int CW    = $clog2(IN_W + 1);
  localparam int RW    = $clog2(IN_H + 1);
  localparam int LB_AW = CW - 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          in_win, cap_pair, wr_line, emit, last_win;

  logic [NUM_CH-1:0][ACT_W-1:0] pooled;
  logic [NUM_CH-1:0][ACT_W-1:0] data_out_q, data_out_d;
  logic                         valid_out_q, valid_out_d;
  logic                         frame_done_q, frame_done_d;

  // Raster position advances only on accepted beats; wraps straight into the next frame.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_q == CW'(IN_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IN_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Window phase decode; a trailing odd column/row falls outside the window grid.
  always_comb begin
    in_win   = (col_q < CW'(2 * PW)) && (row_q < RW'(2 * PH));
    cap_pair = valid_in && in_win && !col_q[0];
    wr_line  = valid_in && in_win &&  col_q[0] && !row_q[0];
    emit     = valid_in && in_win &&  col_q[0] &&  row_q[0];
    last_win = emit && (col_q == CW'(2 * PW - 1)) && (row_q == RW'(2 * PH - 1));
  end

  // Position counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    pool_ch #(
      .PW    (PW),
      .LB_AW (LB_AW),
      .SHIFT (SHIFT)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .x        (data_in[ch*ACC_W +: ACC_W]),
      .cap_pair (cap_pair),
      .wr_line  (wr_line),
      .lb_idx   (col_q[CW-1:1]),
      .pooled   (pooled[ch])
    );
  end

  // Output stage: data holds its last pooled value between windows.
  always_comb begin
    valid_out_d  = emit;
    frame_done_d = last_win;
    data_out_d   = emit ? pooled : data_out_q;
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_out_q   <= '0;
    end else begin
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
      data_out_q   <= data_out_d;
    end
  end

  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;
  assign data_out   = data_out_q;

endmodule
